// File: rtl/uart_rx_frame_if.sv
// Receive-FIFO read port between uart_rx_frame and the UART register block.
interface uart_rx_frame_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_parity_err;
    logic       out_frame_err;

    modport master (
        output out_valid, out_data, out_parity_err, out_frame_err,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_parity_err, out_frame_err,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: 2-flop rx synchroniser, mid-bit sampling FSM and FWFT receive FIFO.
// Optional even parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic [DIV_W-1:0]   divisor,
    uart_rx_frame_if.master    out_if,
    output logic               overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_e;

    typedef struct packed {
        logic       frame_err;
`ifdef UART_RX_PARITY_EN
        logic       parity_err;
`endif
        logic [7:0] data;
    } entry_t;

    logic       rx_meta_q, rs_q;
    state_e     state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_q, parity_err_d;
`endif

    logic [DIV_W-1:0] div_eff, full_l, half_l;
    logic             tick;
    logic             push;
    entry_t           wr_entry;

    assign div_eff = (divisor < DIV_W'(4)) ? DIV_W'(4) : divisor;
    assign full_l  = div_eff - DIV_W'(1);
    assign half_l  = (div_eff >> 1) - DIV_W'(1);
    assign tick    = (cnt_q == '0);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - DIV_W'(1);
        idx_d   = idx_q;
        data_d  = data_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        push    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rs_q) begin
                    state_d = ST_START;
                    cnt_d   = half_l;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rs_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                        cnt_d   = full_l;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = 1'b0;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    data_d[idx_q] = rs_q;
                    idx_d         = idx_q + 3'd1;
                    cnt_d         = full_l;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    parity_err_d = (^data_q) ^ rs_q;
                    cnt_d        = full_l;
                    state_d      = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    push    = 1'b1;
                    state_d = rs_q ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_entry           = '0;
        wr_entry.frame_err = ~rs_q;
        wr_entry.data      = data_q;
`ifdef UART_RX_PARITY_EN
        wr_entry.parity_err = parity_err_q;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rs_q      <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rs_q      <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             full, pop, wr_en;
    entry_t           head;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop   = (count_q != '0) && out_if.out_ready;
    assign wr_en = push && (!full || pop);

    always_comb begin
        overrun_d = push && full && !pop;
        wr_ptr_d  = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
        else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: storage is not reset; outputs are gated by out_valid so stale slots never show.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head               = mem_q[rd_ptr_q];
    assign out_if.out_valid   = (count_q != '0);
    assign out_if.out_data    = out_if.out_valid ? head.data : 8'h00;
    assign out_if.out_frame_err = out_if.out_valid && head.frame_err;
`ifdef UART_RX_PARITY_EN
    assign out_if.out_parity_err = out_if.out_valid && head.parity_err;
`else
    assign out_if.out_parity_err = 1'b0;
`endif
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed self-checking bench for uart_rx_frame; works with or without UART_RX_PARITY_EN.
module tb_uart_rx_frame;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [15:0] divisor;
    logic        overrun;

    uart_rx_frame_if u_if ();

    uart_rx_frame #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .divisor (divisor),
        .out_if  (u_if.master),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
    localparam int  LAT_MAX  = 92;
    localparam logic EXP_PERR = 1'b1;
`else
    localparam int  LAT_MAX  = 84;
    localparam logic EXP_PERR = 1'b0;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   rise_cyc = 0;
    int   ovr_cnt = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (u_if.out_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = u_if.out_valid;
        if (overrun) ovr_cnt = ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller must be aligned at posedge+1; the task returns aligned the same way.
    task automatic send_byte(input logic [7:0] b, input int bp, input logic par_flip,
                             input logic stop_bit, input int rst_at_bit);
        rx = 1'b0;
        start_cyc = cyc;
        wait_bits(bp);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == rst_at_bit) begin
                wait_bits(bp / 2);
                reset = 1'b1;
                wait_bits(1);
                reset = 1'b0;
                check("reset_clears_valid", u_if.out_valid, 0);
                wait_bits(bp - bp / 2 - 1);
            end else begin
                wait_bits(bp);
            end
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        wait_bits(bp);
`endif
        rx = stop_bit;
        wait_bits(bp);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!u_if.out_valid && n < 200) begin
            wait_bits(1);
            n++;
        end
        check(tag, u_if.out_valid, 1);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d, input logic perr, input logic ferr);
        wait_valid({tag, "_valid"});
        check({tag, "_data"}, u_if.out_data, d);
        check({tag, "_perr"}, u_if.out_parity_err, perr);
        check({tag, "_ferr"}, u_if.out_frame_err, ferr);
        u_if.out_ready = 1'b1;
        wait_bits(1);
        u_if.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        divisor = 16'd8;
        u_if.out_ready = 1'b0;
        wait_bits(3);
        check("rst_valid", u_if.out_valid, 0);
        check("rst_data", u_if.out_data, 0);
        check("rst_perr", u_if.out_parity_err, 0);
        check("rst_ferr", u_if.out_frame_err, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        wait_bits(4);

        // Clean frame and start-edge-to-valid latency
        send_byte(8'h55, 8, 1'b0, 1'b1, -1);
        wait_valid("t1_valid");
        check("t1_latency_ok", ((rise_cyc - start_cyc) <= LAT_MAX), 1);
        pop_expect("t1", 8'h55, 1'b0, 1'b0);
        check("t1_empty", u_if.out_valid, 0);

        // Wrong parity bit
        send_byte(8'hA3, 8, 1'b1, 1'b1, -1);
        pop_expect("t2", 8'hA3, EXP_PERR, 1'b0);

        // Low stop bit, line held low (break), then a clean frame
        send_byte(8'h3C, 8, 1'b0, 1'b0, -1);
        wait_bits(16);
        rx = 1'b1;
        wait_bits(20);
        send_byte(8'h81, 8, 1'b0, 1'b1, -1);
        wait_bits(4);
        pop_expect("t3a", 8'h3C, 1'b0, 1'b1);
        pop_expect("t3b", 8'h81, 1'b0, 1'b0);
        check("t3_empty", u_if.out_valid, 0);

        // 3-clock glitch is rejected
        rx = 1'b0;
        wait_bits(3);
        rx = 1'b1;
        wait_bits(20);
        check("t4_no_entry", u_if.out_valid, 0);
        send_byte(8'h42, 8, 1'b0, 1'b1, -1);
        pop_expect("t4", 8'h42, 1'b0, 1'b0);

        // Back-to-back frames into a full FIFO
        ovr_cnt = 0;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 8, 1'b0, 1'b1, -1);
        wait_bits(2);
        check("t5_no_ovr_yet", ovr_cnt, 0);
        send_byte(8'h05, 8, 1'b0, 1'b1, -1);
        wait_bits(4);
        check("t5_ovr_once", ovr_cnt, 1);
        for (int i = 1; i <= 4; i++) pop_expect("t5_drain", 8'(i), 1'b0, 1'b0);
        check("t5_empty", u_if.out_valid, 0);

        // Reset mid-frame discards FIFO and partial frame
        send_byte(8'h99, 8, 1'b0, 1'b1, -1);
        wait_valid("t6_pre_valid");
        send_byte(8'hF1, 8, 1'b0, 1'b1, 4);
        wait_bits(20);
        check("t6_no_entry", u_if.out_valid, 0);
        send_byte(8'hC7, 8, 1'b0, 1'b1, -1);
        pop_expect("t6", 8'hC7, 1'b0, 1'b0);
        check("t6_empty", u_if.out_valid, 0);

        // Divisor below 4 behaves as 4
        divisor = 16'd0;
        wait_bits(2);
        send_byte(8'h96, 4, 1'b0, 1'b1, -1);
        pop_expect("t7_clamp", 8'h96, 1'b0, 1'b0);
        divisor = 16'd8;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
